// File: rtl/mem_arbiter.sv
// Shares one fixed-latency external memory port between video, CPU and host loader,
// with periodic refresh. One access in flight; each requester sees a one-cycle ack.
module mem_arbiter #(
  parameter int AW      = 22,
  parameter int LATENCY = 2,
  parameter int REF_PER = 512,
  parameter int STARVE  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vReq,
  input  logic [AW-1:0] vA,
  output logic [7:0]    vQ,
  output logic          vAck,
  input  logic          cReq,
  input  logic          cWr,
  input  logic [AW-1:0] cA,
  input  logic [7:0]    cD,
  output logic [7:0]    cQ,
  output logic          cAck,
  input  logic          hReq,
  input  logic          hWr,
  input  logic [AW-1:0] hA,
  input  logic [7:0]    hD,
  output logic [7:0]    hQ,
  output logic          hAck,
  output logic [AW-1:0] memA,
  output logic [7:0]    memD,
  input  logic [7:0]    memQ,
  output logic          memR,
  output logic          memW,
  output logic          rfsh
);
  localparam int RW = (REF_PER > 1) ? $clog2(REF_PER) : 1;
  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_VID, G_REF, G_CPU, G_HOST} grant_t;

  state_t          state_q, state_d;
  grant_t          grant_q, grant_d;
  logic            wr_q, wr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   memA_q, memA_d;
  logic [7:0]      memD_q, memD_d;
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic            ref_pend_q, ref_pend_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [7:0]      vQ_q, vQ_d, cQ_q, cQ_d, hQ_q, hQ_d;
  logic            vAck_q, vAck_d, cAck_q, cAck_d, hAck_q, hAck_d;
  logic            ref_grant, host_first;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= G_VID;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      memA_q     <= '0;
      memD_q     <= '0;
      ref_cnt_q  <= RW'(REF_PER - 1);
      ref_pend_q <= 1'b0;
      starve_q   <= '0;
      vQ_q       <= '0;
      cQ_q       <= '0;
      hQ_q       <= '0;
      vAck_q     <= 1'b0;
      cAck_q     <= 1'b0;
      hAck_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      memA_q     <= memA_d;
      memD_q     <= memD_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      starve_q   <= starve_d;
      vQ_q       <= vQ_d;
      cQ_q       <= cQ_d;
      hQ_q       <= hQ_d;
      vAck_q     <= vAck_d;
      cAck_q     <= cAck_d;
      hAck_q     <= hAck_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    memA_d     = memA_q;
    memD_d     = memD_q;
    starve_d   = starve_q;
    ref_grant  = (state_q == S_IDLE) && !vReq && ref_pend_q;
    host_first = (starve_q == SW'(STARVE)) && hReq;
    case (state_q)
      S_IDLE: begin
        if (vReq) begin
          state_d = S_ISSUE;
          grant_d = G_VID;
          wr_d    = 1'b0;
          memA_d  = vA;
        end else if (ref_pend_q) begin
          state_d = S_ISSUE;
          grant_d = G_REF;
          wr_d    = 1'b0;
        end else if (cReq && !host_first) begin
          state_d = S_ISSUE;
          grant_d = G_CPU;
          wr_d    = cWr;
          memA_d  = cA;
          memD_d  = cD;
          if (hReq && starve_q != SW'(STARVE)) starve_d = starve_q + SW'(1);
        end else if (hReq) begin
          state_d  = S_ISSUE;
          grant_d  = G_HOST;
          wr_d     = hWr;
          memA_d   = hA;
          memD_d   = hD;
          starve_d = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!hReq) starve_d = '0;

    // A fresh expiry wins over a same-cycle grant; a pending one is merged.
    ref_cnt_d  = (ref_cnt_q == '0) ? RW'(REF_PER - 1) : ref_cnt_q - RW'(1);
    ref_pend_d = ref_pend_q;
    if (ref_grant)         ref_pend_d = 1'b0;
    if (ref_cnt_q == '0)   ref_pend_d = 1'b1;
  end

  always_comb begin
    vAck_d = 1'b0;
    cAck_d = 1'b0;
    hAck_d = 1'b0;
    vQ_d   = vQ_q;
    cQ_d   = cQ_q;
    hQ_d   = hQ_q;
    memR   = (state_q == S_ISSUE) && (grant_q != G_REF) && !wr_q;
    memW   = (state_q == S_ISSUE) && (grant_q != G_REF) && wr_q;
    rfsh   = (state_q == S_ISSUE) && (grant_q == G_REF);
    if (state_q == S_DONE) begin
      case (grant_q)
        G_VID: begin
          vAck_d = 1'b1;
          vQ_d   = memQ;
        end
        G_CPU: begin
          cAck_d = 1'b1;
          if (!wr_q) cQ_d = memQ;
        end
        G_HOST: begin
          hAck_d = 1'b1;
          if (!wr_q) hQ_d = memQ;
        end
        default: ;
      endcase
    end
  end

  assign memA = memA_q;
  assign memD = memD_q;
  assign vQ   = vQ_q;
  assign cQ   = cQ_q;
  assign hQ   = hQ_q;
  assign vAck = vAck_q;
  assign cAck = cAck_q;
  assign hAck = hAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small latency-accurate memory model answers reads
// with memA[7:0]^8'h5A; a second instance with REF_PER=16 exercises refresh spacing.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        vReq = 1'b0, cReq = 1'b0, cWr = 1'b0, hReq = 1'b0, hWr = 1'b0;
  logic [21:0] vA = '0, cA = '0, hA = '0;
  logic [7:0]  cD = '0, hD = '0, memQ = '0;
  logic [7:0]  vQ, cQ, hQ, memD;
  logic        vAck, cAck, hAck, memR, memW, rfsh;
  logic [21:0] memA;

  logic [7:0]  r_vQ, r_cQ, r_hQ, r_memD;
  logic        r_vAck, r_cAck, r_hAck, r_memR, r_memW, r_rfsh;
  logic [21:0] r_memA;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(22), .LATENCY(LAT), .REF_PER(512), .STARVE(4)) dut (
    .clock(clock), .reset(reset),
    .vReq(vReq), .vA(vA), .vQ(vQ), .vAck(vAck),
    .cReq(cReq), .cWr(cWr), .cA(cA), .cD(cD), .cQ(cQ), .cAck(cAck),
    .hReq(hReq), .hWr(hWr), .hA(hA), .hD(hD), .hQ(hQ), .hAck(hAck),
    .memA(memA), .memD(memD), .memQ(memQ), .memR(memR), .memW(memW), .rfsh(rfsh)
  );

  mem_arbiter #(.AW(22), .LATENCY(LAT), .REF_PER(16), .STARVE(4)) dut_r (
    .clock(clock), .reset(reset),
    .vReq(1'b0), .vA(22'h0), .vQ(r_vQ), .vAck(r_vAck),
    .cReq(1'b0), .cWr(1'b0), .cA(22'h0), .cD(8'h0), .cQ(r_cQ), .cAck(r_cAck),
    .hReq(1'b0), .hWr(1'b0), .hA(22'h0), .hD(8'h0), .hQ(r_hQ), .hAck(r_hAck),
    .memA(r_memA), .memD(r_memD), .memQ(8'h00), .memR(r_memR), .memW(r_memW), .rfsh(r_rfsh)
  );

  // Memory model: data appears LAT cycles after the memR cycle and stays two cycles.
  int       q_dly = 0, q_hold = 0;
  logic [7:0] q_data = '0;
  always @(posedge clock) begin
    #1;
    if (q_hold > 0) begin
      q_hold--;
      if (q_hold == 0) memQ = 8'h00;
    end
    if (q_dly > 0) begin
      q_dly--;
      if (q_dly == 0) begin
        memQ   = q_data;
        q_hold = 2;
      end
    end
    if (memR) begin
      q_dly  = LAT;
      q_data = memA[7:0] ^ 8'h5A;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vReq = 1'b0; cReq = 1'b0; hReq = 1'b0; cWr = 1'b0; hWr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vReq = 1'b1; cReq = 1'b1; hReq = 1'b1; cWr = 1'b0; hWr = 1'b0;
    vA = 22'h000011; cA = 22'h000022; hA = 22'h000033;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({memR, memW, rfsh, vAck, cAck, hAck} !== 6'b0 || memA !== 22'h0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d strobes/acks=%b memA=%h, want 0/0", i,
                 {memR, memW, rfsh, vAck, cAck, hAck}, memA);
      end
    end
    checks++;
    if ({vQ, cQ, hQ} !== 24'h0) begin
      failures++;
      $display("FAIL reset_q got=%h want 0", {vQ, cQ, hQ});
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({vAck, cAck, hAck} !== 3'b0) begin
        failures++;
        $display("FAIL reset_release_noack cyc=%0d acks=%b want 000", i, {vAck, cAck, hAck});
      end
    end
  endtask

  task automatic test_cpu_read();
    int nr = 0, nw = 0, ack_at = 0;
    logic [21:0] a_seen = '0;
    logic [7:0]  q_seen = '0;
    do_reset();
    tick();
    cA = 22'h01C000; cWr = 1'b0; cReq = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (memR) begin nr++; a_seen = memA; end
      if (memW) nw++;
      if (cAck && ack_at == 0) begin
        ack_at = k; q_seen = cQ; cReq = 1'b0;
      end
    end
    checks++;
    if (nr != 1 || nw != 0) begin
      failures++;
      $display("FAIL cpu_read_strobes memR=%0d memW=%0d want 1/0", nr, nw);
    end
    checks++;
    if (a_seen !== 22'h01C000) begin
      failures++;
      $display("FAIL cpu_read_addr got=%h want 01c000", a_seen);
    end
    checks++;
    if (ack_at != LAT + 3) begin
      failures++;
      $display("FAIL cpu_read_latency got=%0d want %0d", ack_at, LAT + 3);
    end
    checks++;
    if (q_seen !== 8'h5A) begin
      failures++;
      $display("FAIL cpu_read_data got=%h want 5a", q_seen);
    end
  endtask

  task automatic test_priority();
    int v_at = 0, c_at = 0;
    logic [7:0] vq = '0, cq = '0;
    do_reset();
    tick();
    vA = 22'h000123; cA = 22'h0000F0; cWr = 1'b0;
    vReq = 1'b1; cReq = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (vAck && v_at == 0) begin v_at = k; vq = vQ; vReq = 1'b0; end
      if (cAck && c_at == 0) begin c_at = k; cq = cQ; cReq = 1'b0; end
    end
    checks++;
    if (v_at != LAT + 3) begin
      failures++;
      $display("FAIL prio_video_first vAck_at=%0d want %0d", v_at, LAT + 3);
    end
    checks++;
    if (c_at - v_at != LAT + 3) begin
      failures++;
      $display("FAIL prio_cpu_after cAck-vAck=%0d want %0d", c_at - v_at, LAT + 3);
    end
    checks++;
    if (vq !== 8'h79 || cq !== 8'hAA) begin
      failures++;
      $display("FAIL prio_data vQ=%h cQ=%h want 79/aa", vq, cq);
    end
  endtask

  task automatic test_starve();
    logic [9:0] seq = '0;
    logic [9:0] want = 10'b10000_10000;  // bit i = 1 when ack i is the host's
    int nacks = 0, nw = 0, bad_d = 0, first_at = 0;
    do_reset();
    tick();
    cA = 22'h0000C1; cD = 8'h3C; cWr = 1'b1;
    hA = 22'h200010; hD = 8'hC3; hWr = 1'b1;
    cReq = 1'b1; hReq = 1'b1;
    for (int k = 1; k <= 60 && nacks < 10; k++) begin
      tick();
      if (memW) begin
        nw++;
        if (!((memA == cA && memD == cD) || (memA == hA && memD == hD))) bad_d++;
      end
      if (cAck || hAck) begin
        if (nacks == 0) first_at = k;
        seq[nacks] = hAck;
        nacks++;
      end
    end
    cReq = 1'b0; hReq = 1'b0;
    checks++;
    if (seq !== want || nacks != 10) begin
      failures++;
      $display("FAIL starve_order got=%b n=%0d want %b n=10", seq, nacks, want);
    end
    checks++;
    if (nw != 10 || bad_d != 0) begin
      failures++;
      $display("FAIL starve_writes memW=%0d bad_addr_data=%0d want 10/0", nw, bad_d);
    end
    checks++;
    if (first_at != LAT + 3) begin
      failures++;
      $display("FAIL starve_first_ack got=%0d want %0d", first_at, LAT + 3);
    end
    checks++;
    if (cQ !== 8'h00 || hQ !== 8'h00) begin
      failures++;
      $display("FAIL starve_q_hold cQ=%h hQ=%h want 00/00", cQ, hQ);
    end
  endtask

  task automatic test_refresh();
    int last = 0, first = 0, n = 0, bad_gap = 0, other = 0;
    do_reset();
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (r_memR || r_memW || r_vAck || r_cAck || r_hAck) other++;
      if (r_rfsh) begin
        if (n == 0) first = k;
        else if (k - last != 16) bad_gap++;
        last = k;
        n++;
      end
    end
    checks++;
    if (n < 4 || bad_gap != 0) begin
      failures++;
      $display("FAIL refresh_period pulses=%0d bad_gaps=%0d want >=4/0", n, bad_gap);
    end
    checks++;
    if (first < 16 || first > 18) begin
      failures++;
      $display("FAIL refresh_first got=%0d want 16..18", first);
    end
    checks++;
    if (other != 0) begin
      failures++;
      $display("FAIL refresh_quiet stray_strobes=%0d want 0", other);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0, ack_at = 0;
    logic [7:0] q_seen = '0;
    do_reset();
    tick();
    cA = 22'h000033; cWr = 1'b0; cReq = 1'b1;
    tick();
    tick();
    reset = 1'b0; cReq = 1'b0;
    tick();
    if (cAck) stray++;
    reset = 1'b1;
    cA = 22'h000044; cReq = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cAck && ack_at == 0) begin
        ack_at = k; q_seen = cQ; cReq = 1'b0;
      end
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midreset_noack stray=%0d want 0", stray);
    end
    checks++;
    if (ack_at != LAT + 3) begin
      failures++;
      $display("FAIL midreset_latency got=%0d want %0d", ack_at, LAT + 3);
    end
    checks++;
    if (q_seen !== 8'h1E) begin
      failures++;
      $display("FAIL midreset_data got=%h want 1e", q_seen);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_starve();
    test_refresh();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
